// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: D-stage decode inputs, E-stage hazard and ALU flag inputs,
// and the decoded control outputs for E, M and W.
// The performance counter ports exist only when PCTRL_PERF_CNT_EN is defined.
interface pipe_ctrl_unit_if #(
    parameter int ALUCTL_W = 3
`ifdef PCTRL_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic [6:0]          opD;
    logic [2:0]          funct3D;
    logic                funct7b5D;
    logic                StallE;
    logic                FlushE;
    logic                ZeroE;
    logic                LtE;
    logic                LtuE;
    logic [2:0]          ImmSrcD;
    logic                IllegalD;
    logic                PCSrcE;
    logic [ALUCTL_W-1:0] ALUControlE;
    logic                ALUSrcAE;
    logic                ALUSrcBE;
    logic                ResultSrcEb0;
    logic                MemWriteM;
    logic                RegWriteM;
    logic [2:0]          Funct3M;
    logic                RegWriteW;
    logic [1:0]          ResultSrcW;
`ifdef PCTRL_PERF_CNT_EN
    logic [CNT_W-1:0]    BrTakenCnt;
    logic [CNT_W-1:0]    FlushCnt;
`endif

    modport slave (
        input  opD, funct3D, funct7b5D, StallE, FlushE, ZeroE, LtE, LtuE,
        output ImmSrcD, IllegalD, PCSrcE, ALUControlE, ALUSrcAE, ALUSrcBE,
               ResultSrcEb0, MemWriteM, RegWriteM, Funct3M, RegWriteW, ResultSrcW
`ifdef PCTRL_PERF_CNT_EN
        , output BrTakenCnt, FlushCnt
`endif
    );

    modport master (
        output opD, funct3D, funct7b5D, StallE, FlushE, ZeroE, LtE, LtuE,
        input  ImmSrcD, IllegalD, PCSrcE, ALUControlE, ALUSrcAE, ALUSrcBE,
               ResultSrcEb0, MemWriteM, RegWriteM, Funct3M, RegWriteW, ResultSrcW
`ifdef PCTRL_PERF_CNT_EN
        , input BrTakenCnt, FlushCnt
`endif
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// RV32I pipelined control unit. Decodes in D, carries control through E,
// a MEM_STAGES-deep M chain and W. Branch conditions are resolved in E.
// Optional feature macro PCTRL_PERF_CNT_EN adds saturating counters for
// taken branches/jumps and E flushes.
module pipe_ctrl_unit #(
    parameter int ALUCTL_W   = 3,
    parameter int MEM_STAGES = 1
`ifdef PCTRL_PERF_CNT_EN
    , parameter int CNT_W    = 16
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    pipe_ctrl_unit_if.slave        bus
);

    // Control carried in the E register.
    typedef struct packed {
        logic                reg_write;
        logic [1:0]          result_src;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic [ALUCTL_W-1:0] alu_ctl;
        logic                src_a;
        logic                src_b;
        logic [2:0]          funct3;
    } ectl_t;

    // Write-back control carried through every M stage and into W.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_t;

    // Memory-access control needed only in the first M stage.
    typedef struct packed {
        logic       mem_write;
        logic [2:0] funct3;
    } mem_t;

    ectl_t      dec_s;
    ectl_t      e_next_s;
    ectl_t      e_r;
    logic [2:0] imm_src_s;
    logic       illegal_s;
    logic [1:0] alu_op_s;
    logic [2:0] alu_code_s;
    logic       cond_s;
    logic       pcsrc_s;
    wb_t        m_wb_in_s;
    mem_t       m_mem_in_s;
    wb_t        m_wb_r [MEM_STAGES];
    mem_t       m_mem_r;
    wb_t        w_r;

    // Main and ALU decode of the D-stage instruction; unknown opcodes decode to a bubble.
    always_comb begin
        dec_s      = '0;
        imm_src_s  = 3'b000;
        illegal_s  = 1'b0;
        alu_op_s   = 2'b00;
        alu_code_s = 3'd0;
        case (bus.opD)
            7'b0000011: begin // lw
                dec_s.reg_write  = 1'b1;
                dec_s.result_src = 2'b01;
                dec_s.src_b      = 1'b1;
            end
            7'b0100011: begin // sw
                dec_s.mem_write  = 1'b1;
                dec_s.src_b      = 1'b1;
                imm_src_s        = 3'b001;
            end
            7'b0110011: begin // R-type
                dec_s.reg_write  = 1'b1;
                alu_op_s         = 2'b10;
            end
            7'b0010011: begin // I-type ALU
                dec_s.reg_write  = 1'b1;
                dec_s.src_b      = 1'b1;
                alu_op_s         = 2'b10;
            end
            7'b1100011: begin // conditional branches
                dec_s.branch     = 1'b1;
                imm_src_s        = 3'b010;
                alu_op_s         = 2'b01;
            end
            7'b1101111: begin // jal: ALU forms PC + imm
                dec_s.reg_write  = 1'b1;
                dec_s.result_src = 2'b10;
                dec_s.jump       = 1'b1;
                dec_s.src_a      = 1'b1;
                dec_s.src_b      = 1'b1;
                imm_src_s        = 3'b011;
            end
            7'b1100111: begin // jalr: ALU forms rs1 + imm
                dec_s.reg_write  = 1'b1;
                dec_s.result_src = 2'b10;
                dec_s.jump       = 1'b1;
                dec_s.src_b      = 1'b1;
            end
            7'b0110111: begin // lui: add with operand A at zero passes the immediate
                dec_s.reg_write  = 1'b1;
                dec_s.src_b      = 1'b1;
                imm_src_s        = 3'b100;
            end
            7'b0010111: begin // auipc
                dec_s.reg_write  = 1'b1;
                dec_s.src_a      = 1'b1;
                dec_s.src_b      = 1'b1;
                imm_src_s        = 3'b100;
            end
            default: begin
                illegal_s        = 1'b1;
            end
        endcase

        case (alu_op_s)
            2'b00: alu_code_s = 3'd0;
            2'b01: alu_code_s = 3'd1;
            2'b10: begin
                case (bus.funct3D)
                    3'b000:  alu_code_s = (bus.opD[5] & bus.funct7b5D) ? 3'd1 : 3'd0;
                    3'b001:  alu_code_s = 3'd6;
                    3'b010:  alu_code_s = 3'd5;
                    3'b011:  alu_code_s = 3'd5;
                    3'b100:  alu_code_s = 3'd4;
                    3'b101:  alu_code_s = 3'd7;
                    3'b110:  alu_code_s = 3'd3;
                    3'b111:  alu_code_s = 3'd2;
                    default: alu_code_s = 3'd0;
                endcase
            end
            default: alu_code_s = 3'd0;
        endcase

        dec_s.alu_ctl = ALUCTL_W'(alu_code_s);
        if (illegal_s) begin
            dec_s.funct3 = 3'b000;
        end else begin
            dec_s.funct3 = bus.funct3D;
        end
    end

    // Next E contents: flush beats stall, stall beats a normal load.
    always_comb begin
        if (bus.FlushE) begin
            e_next_s = '0;
        end else if (bus.StallE) begin
            e_next_s = e_r;
        end else begin
            e_next_s = dec_s;
        end
    end

    // E control register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_r <= '0;
        end else begin
            e_r <= e_next_s;
        end
    end

    // A held E instruction has not advanced, so M receives a bubble instead of a duplicate.
    always_comb begin
        m_wb_in_s  = '0;
        m_mem_in_s = '0;
        if (bus.StallE && !bus.FlushE) begin
            m_wb_in_s  = '0;
            m_mem_in_s = '0;
        end else begin
            m_wb_in_s.reg_write  = e_r.reg_write;
            m_wb_in_s.result_src = e_r.result_src;
            m_mem_in_s.mem_write = e_r.mem_write;
            m_mem_in_s.funct3    = e_r.funct3;
        end
    end

    // M chain and W register; never stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_STAGES; i++) begin
                m_wb_r[i] <= '0;
            end
            m_mem_r <= '0;
            w_r     <= '0;
        end else begin
            m_wb_r[0] <= m_wb_in_s;
            for (int i = 1; i < MEM_STAGES; i++) begin
                m_wb_r[i] <= m_wb_r[i-1];
            end
            m_mem_r <= m_mem_in_s;
            w_r     <= m_wb_r[MEM_STAGES-1];
        end
    end

    // Branch condition selected by the funct3 travelling with the E instruction.
    always_comb begin
        case (e_r.funct3)
            3'b000:  cond_s = bus.ZeroE;
            3'b001:  cond_s = ~bus.ZeroE;
            3'b100:  cond_s = bus.LtE;
            3'b101:  cond_s = ~bus.LtE;
            3'b110:  cond_s = bus.LtuE;
            3'b111:  cond_s = ~bus.LtuE;
            default: cond_s = 1'b0;
        endcase
    end

    assign pcsrc_s = (e_r.branch & cond_s) | e_r.jump;

    assign bus.ImmSrcD      = imm_src_s;
    assign bus.IllegalD     = illegal_s;
    assign bus.PCSrcE       = pcsrc_s;
    assign bus.ALUControlE  = e_r.alu_ctl;
    assign bus.ALUSrcAE     = e_r.src_a;
    assign bus.ALUSrcBE     = e_r.src_b;
    assign bus.ResultSrcEb0 = e_r.result_src[0];
    assign bus.MemWriteM    = m_mem_r.mem_write;
    assign bus.RegWriteM    = m_wb_r[0].reg_write;
    assign bus.Funct3M      = m_mem_r.funct3;
    assign bus.RegWriteW    = w_r.reg_write;
    assign bus.ResultSrcW   = w_r.result_src;

`ifdef PCTRL_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating counters of redirecting cycles and E flush cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt_r    <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (pcsrc_s && (br_cnt_r != {CNT_W{1'b1}})) begin
                br_cnt_r <= br_cnt_r + CNT_W'(1);
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (bus.FlushE && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.BrTakenCnt = br_cnt_r;
    assign bus.FlushCnt   = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit. Two instances (MEM_STAGES 1 and 2)
// share the same stimulus. Define PCTRL_PERF_CNT_EN to also check the counters.
module tb_pipe_ctrl_unit;

`ifdef PCTRL_PERF_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op_d = 7'd0;
    logic [2:0] f3_d = 3'd0;
    logic       f7_d = 1'b0;
    logic       stall_e = 1'b0;
    logic       flush_e = 1'b0;
    logic       zero_e = 1'b0;
    logic       lt_e = 1'b0;
    logic       ltu_e = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

`ifdef PCTRL_PERF_CNT_EN
    pipe_ctrl_unit_if #(.ALUCTL_W(3), .CNT_W(CNT_W)) b1 ();
    pipe_ctrl_unit_if #(.ALUCTL_W(3), .CNT_W(CNT_W)) b2 ();
    pipe_ctrl_unit #(.ALUCTL_W(3), .MEM_STAGES(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    pipe_ctrl_unit #(.ALUCTL_W(3), .MEM_STAGES(2), .CNT_W(CNT_W)) dut2 (.clk(clk), .reset(reset), .bus(b2));
`else
    pipe_ctrl_unit_if #(.ALUCTL_W(3)) b1 ();
    pipe_ctrl_unit_if #(.ALUCTL_W(3)) b2 ();
    pipe_ctrl_unit #(.ALUCTL_W(3), .MEM_STAGES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    pipe_ctrl_unit #(.ALUCTL_W(3), .MEM_STAGES(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
`endif

    assign b1.opD = op_d;       assign b2.opD = op_d;
    assign b1.funct3D = f3_d;   assign b2.funct3D = f3_d;
    assign b1.funct7b5D = f7_d; assign b2.funct7b5D = f7_d;
    assign b1.StallE = stall_e; assign b2.StallE = stall_e;
    assign b1.FlushE = flush_e; assign b2.FlushE = flush_e;
    assign b1.ZeroE = zero_e;   assign b2.ZeroE = zero_e;
    assign b1.LtE = lt_e;       assign b2.LtE = lt_e;
    assign b1.LtuE = ltu_e;     assign b2.LtuE = ltu_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Stimulus + expected values, all hand-derived.
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       lt;
        logic       ltu;
        logic [2:0] imm;
        logic       ill;
        logic [2:0] alu;
        logic       sa;
        logic       sb;
        logic       rs0;
        logic       pc;
        logic       mw;
        logic       rw;
        logic [1:0] rs;
    } vec_t;

    localparam int N = 25;
    vec_t v [N];

    initial begin
        // op, f3, f7, zero, lt, ltu | imm, ill, alu, srcA, srcB, rs0, pcsrc, memw, regw, resultsrc
        v[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // add
        v[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // sub
        v[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // addi, b30 set
        v[3]  = '{7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // xori
        v[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // and
        v[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // or
        v[6]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // slti
        v[7]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // sll
        v[8]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // srl
        v[9]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01}; // lw
        v[10] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}; // sw
        v[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // beq taken
        v[12] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // bne not taken
        v[13] = '{7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // blt taken
        v[14] = '{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // bltu taken
        v[15] = '{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // bge not taken
        v[16] = '{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // bgeu taken
        v[17] = '{7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // f3=010 never
        v[18] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10}; // jal
        v[19] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10}; // jalr
        v[20] = '{7'b0110111, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // lui
        v[21] = '{7'b0010111, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; // auipc
        v[22] = '{7'b0000000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // illegal
        v[23] = '{7'b1111111, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // illegal
        v[24] = '{7'b0110001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // illegal

        // ---- reset held with a jal in D: nothing may leave reset ----
        op_d = 7'b1101111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pcsrc", {31'd0, b1.PCSrcE}, 32'd0);
        chk("rst_e", {b1.ALUControlE, b1.ALUSrcAE, b1.ALUSrcBE, b1.ResultSrcEb0}, 32'd0);
        chk("rst_m", {b1.MemWriteM, b1.RegWriteM, b1.Funct3M}, 32'd0);
        chk("rst_w", {b1.RegWriteW, b1.ResultSrcW, b2.RegWriteW, b2.ResultSrcW}, 32'd0);
`ifdef PCTRL_PERF_CNT_EN
        chk("rst_cnt", {b1.BrTakenCnt, b1.FlushCnt}, 32'd0);
`endif
        op_d = 7'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_pcsrc", {31'd0, b1.PCSrcE}, 32'd0);
        chk("idle_e", {b1.ALUControlE, b1.ALUSrcAE, b1.ALUSrcBE, b1.ResultSrcEb0}, 32'd0);

        // ---- table-driven pipeline: D at i, E at i+1, M at i+2, W at i+3 / i+4 ----
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (i < N) begin
                op_d = v[i].op; f3_d = v[i].f3; f7_d = v[i].f7;
            end else begin
                op_d = 7'd0; f3_d = 3'd0; f7_d = 1'b0;
            end
            #1;
            if (i < N) begin
                chk($sformatf("ImmSrcD[%0d]", i), {29'd0, b1.ImmSrcD}, {29'd0, v[i].imm});
                chk($sformatf("IllegalD[%0d]", i), {31'd0, b1.IllegalD}, {31'd0, v[i].ill});
            end
            @(posedge clk); #1;
            if (i < N) begin
                zero_e = v[i].z; lt_e = v[i].lt; ltu_e = v[i].ltu;
                #1;
                chk($sformatf("ALUControlE[%0d]", i), {29'd0, b1.ALUControlE}, {29'd0, v[i].alu});
                chk($sformatf("SrcAB_E[%0d]", i), {30'd0, b1.ALUSrcAE, b1.ALUSrcBE}, {30'd0, v[i].sa, v[i].sb});
                chk($sformatf("ResultSrcEb0[%0d]", i), {31'd0, b1.ResultSrcEb0}, {31'd0, v[i].rs0});
                chk($sformatf("PCSrcE[%0d]", i), {31'd0, b1.PCSrcE}, {31'd0, v[i].pc});
                chk($sformatf("PCSrcE2[%0d]", i), {31'd0, b2.PCSrcE}, {31'd0, v[i].pc});
            end
            if (i >= 1 && i <= N) begin
                chk($sformatf("M[%0d]", i - 1), {27'd0, b1.MemWriteM, b1.RegWriteM, b1.Funct3M},
                    {27'd0, v[i-1].mw, v[i-1].rw, (v[i-1].ill ? 3'b000 : v[i-1].f3)});
            end
            if (i >= 2 && i <= N + 1) begin
                chk($sformatf("W1[%0d]", i - 2), {29'd0, b1.RegWriteW, b1.ResultSrcW},
                    {29'd0, v[i-2].rw, v[i-2].rs});
            end
            if (i >= 3) begin
                chk($sformatf("W2[%0d]", i - 3), {29'd0, b2.RegWriteW, b2.ResultSrcW},
                    {29'd0, v[i-3].rw, v[i-3].rs});
            end
        end

        // ---- jal in D while FlushE and StallE both high: bubble wins ----
        zero_e = 1'b1; lt_e = 1'b0; ltu_e = 1'b0;
        @(negedge clk);
        op_d = 7'b1100011; f3_d = 3'b001;          // bne, not taken with Zero=1
        @(negedge clk);
        op_d = 7'b1101111; f3_d = 3'b000;          // jal
        flush_e = 1'b1; stall_e = 1'b1;
        @(posedge clk); #1;
        chk("fs_pcsrc", {31'd0, b1.PCSrcE}, 32'd0);
        chk("fs_e", {b1.ALUControlE, b1.ALUSrcAE, b1.ALUSrcBE, b1.ResultSrcEb0}, 32'd0);
        @(negedge clk);
        flush_e = 1'b0; stall_e = 1'b0; op_d = 7'd0;
        @(posedge clk); #1;
        chk("fs_regwm", {30'd0, b1.RegWriteM, b1.MemWriteM}, 32'd0);

        // ---- flush alone squashes a lw entering E ----
        @(negedge clk);
        op_d = 7'b0000011; f3_d = 3'b010; flush_e = 1'b1;
        @(posedge clk); #1;
        chk("flush_rs0", {31'd0, b1.ResultSrcEb0}, 32'd0);
        @(negedge clk);
        flush_e = 1'b0; op_d = 7'd0;

        // ---- lw held in E for two cycles ----
        @(negedge clk);
        op_d = 7'b0000011; f3_d = 3'b010;
        @(posedge clk); #1;
        chk("stall_e0", {31'd0, b1.ResultSrcEb0}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            op_d = 7'b0110011; f3_d = 3'b000; stall_e = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("stall_rs0[%0d]", k), {30'd0, b1.ResultSrcEb0, b1.ALUSrcBE}, 32'd3);
            chk($sformatf("stall_regwm[%0d]", k), {31'd0, b1.RegWriteM}, 32'd0);
        end
        @(negedge clk);
        stall_e = 1'b0; op_d = 7'd0; f3_d = 3'd0;
        #1;
        chk("illegal_op0", {31'd0, b1.IllegalD}, 32'd1);
        @(posedge clk); #1;
        chk("stall_late_m", {28'd0, b1.RegWriteM, b1.Funct3M}, {28'd0, 1'b1, 3'b010});
        chk("stall_e_after", {31'd0, b1.ResultSrcEb0}, 32'd0);
        @(posedge clk); #1;
        chk("stall_late_w", {29'd0, b1.RegWriteW, b1.ResultSrcW}, {29'd0, 1'b1, 2'b01});

        // ---- async reset with a lw in M: nothing reaches W ----
        @(negedge clk);
        op_d = 7'b0000011; f3_d = 3'b010;
        @(negedge clk);
        op_d = 7'd0; f3_d = 3'd0;
        @(posedge clk); #1;
        chk("mid_pre", {31'd0, b1.RegWriteM}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_m", {b1.MemWriteM, b1.RegWriteM, b1.Funct3M, b2.RegWriteM}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_w[%0d]", k), {30'd0, b1.RegWriteW, b2.RegWriteW}, 32'd0);
        end

`ifdef PCTRL_PERF_CNT_EN
        // ---- performance counters, CNT_W=2 ----
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("cnt_rst0", {b1.BrTakenCnt, b1.FlushCnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1; op_d = 7'b1101111;
        repeat (3) @(posedge clk);
        #1;
        chk("br_cnt_2", {30'd0, b1.BrTakenCnt}, 32'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        op_d = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("br_cnt_sat", {30'd0, b1.BrTakenCnt}, 32'd3);
        @(negedge clk);
        flush_e = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush_e = 1'b0;
        chk("flush_cnt_2", {30'd0, b1.FlushCnt}, 32'd2);
        flush_e = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush_e = 1'b0;
        chk("flush_cnt_sat", {30'd0, b1.FlushCnt}, 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("cnt_async_rst", {b1.BrTakenCnt, b1.FlushCnt, b2.BrTakenCnt, b2.FlushCnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
